kbd_sequencer: RTL and testbench

Keyboard front-end sequencer between the PS/2 byte receiver and `scancode_convert`. Queues raw scan bytes, filters keyboard protocol responses, paces bytes into the converter with a guaranteed inter-strobe gap, and buffers the resulting keycodes in a FIFO read by the CPU-side keyboard interface. Sticky overrun flags report lost bytes or keycodes.

---
 rtl/kbd_sequencer_if.sv | 35 +++
 rtl/kbd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_kbd_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_sequencer_if.sv
// Signal bundle between the keyboard sequencer and its environment (PS/2 receiver,
// scancode converter and CPU-side keycode reader).
interface kbd_sequencer_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          conv_strobe;
  logic [7:0]    conv_code;
  logic          conv_reset;
  logic          conv_valid;
  logic [7:0]    conv_keycode;
  logic          kc_valid;
  logic [7:0]    kc_data;
  logic          kc_ack;
  logic [CW-1:0] kc_count;
  logic          rx_overrun;
  logic          kc_overrun;
  logic          clr_overrun;
  logic          kbd_reset_seen;

  modport slave (
    input  rx_valid, rx_data, conv_valid, conv_keycode, kc_ack, clr_overrun,
    output conv_strobe, conv_code, conv_reset, kc_valid, kc_data, kc_count,
           rx_overrun, kc_overrun, kbd_reset_seen
  );

  modport master (
    output rx_valid, rx_data, conv_valid, conv_keycode, kc_ack, clr_overrun,
    input  conv_strobe, conv_code, conv_reset, kc_valid, kc_data, kc_count,
           rx_overrun, kc_overrun, kbd_reset_seen
  );
endinterface

// File: rtl/kbd_sequencer.sv
// Scan bytes -> 4-deep queue -> protocol filter/pacer -> converter; converter keycodes -> DEPTH-deep FIFO.
// Byte reaches conv_strobe 2 cycles after rx_valid, strobes spaced GAP+2; full queues drop and set sticky overrun.
module kbd_sequencer #(
  parameter int GAP   = 100,
  parameter int DEPTH = 8
) (
  input logic            clk,
  input logic            reset_n,
  kbd_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    conv_code_q, conv_code_d;
  logic          conv_strobe_q, conv_strobe_d;
  logic          conv_reset_q, conv_reset_d;
  logic          rst_seen_q, rst_seen_d;

  logic [7:0]    rxq_q [4];
  logic [7:0]    rxq_d [4];
  logic [1:0]    rxq_wr_q, rxq_wr_d, rxq_rd_q, rxq_rd_d;
  logic [2:0]    rxq_cnt_q, rxq_cnt_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          rxq_pop, rxq_push, rxq_full, rx_drop;
  logic [7:0]    head;

  logic [7:0]    kcq_q [DEPTH];
  logic [7:0]    kcq_d [DEPTH];
  logic [AW-1:0] kc_wr_q, kc_wr_d, kc_rd_q, kc_rd_d;
  logic [CW-1:0] kc_cnt_q, kc_cnt_d, kc_left;
  logic [7:0]    kc_data_q, kc_data_d;
  logic          kc_ovr_q, kc_ovr_d;
  logic          kc_pop, kc_push, kc_full, kc_drop;

  // Keyboard protocol responses; none of them is a key in scan set 2.
  function automatic logic is_filtered(input logic [7:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) || (b == 8'hFA) ||
           (b == 8'hFC) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  assign head = rxq_q[rxq_rd_q];

  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    conv_code_d   = conv_code_q;
    conv_strobe_d = 1'b0;
    conv_reset_d  = 1'b0;
    rst_seen_d    = 1'b0;
    rxq_pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxq_cnt_q != 3'd0) begin
          rxq_pop = 1'b1;
          if (is_filtered(head)) begin
            conv_reset_d = (head == 8'hAA);
            rst_seen_d   = (head == 8'hAA);
          end else begin
            conv_code_d   = head;
            conv_strobe_d = 1'b1;
            state_d       = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        gap_d   = GW'(GAP);
      end
      WAIT: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == GW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a write to a full queue still lands.
  always_comb begin
    rxq_full  = (rxq_cnt_q == 3'd4);
    rxq_push  = bus.rx_valid && (!rxq_full || rxq_pop);
    rx_drop   = bus.rx_valid && rxq_full && !rxq_pop;
    rxq_d     = rxq_q;
    if (rxq_push) rxq_d[rxq_wr_q] = bus.rx_data;
    rxq_wr_d  = rxq_wr_q + 2'(rxq_push);
    rxq_rd_d  = rxq_rd_q + 2'(rxq_pop);
    rxq_cnt_d = rxq_cnt_q + 3'(rxq_push) - 3'(rxq_pop);
    rx_ovr_d  = (rx_ovr_q && !bus.clr_overrun) || rx_drop;
  end

  always_comb begin
    kc_full  = (kc_cnt_q == CW'(DEPTH));
    kc_pop   = bus.kc_ack && (kc_cnt_q != '0);
    kc_push  = bus.conv_valid && (!kc_full || kc_pop);
    kc_drop  = bus.conv_valid && kc_full && !kc_pop;
    kcq_d    = kcq_q;
    if (kc_push) kcq_d[kc_wr_q] = bus.conv_keycode;
    kc_wr_d  = kc_wr_q + AW'(kc_push);
    kc_rd_d  = kc_rd_q + AW'(kc_pop);
    kc_cnt_d = kc_cnt_q + CW'(kc_push) - CW'(kc_pop);
    kc_left  = kc_cnt_q - CW'(kc_pop);
    // Head register tracks the post-edge head; an incoming keycode becomes head only if nothing older remains.
    kc_data_d = kc_data_q;
    if (kc_left != '0)  kc_data_d = kcq_q[kc_rd_d];
    else if (kc_push)   kc_data_d = bus.conv_keycode;
    kc_ovr_d = (kc_ovr_q && !bus.clr_overrun) || kc_drop;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      gap_q         <= '0;
      conv_code_q   <= 8'h00;
      conv_strobe_q <= 1'b0;
      conv_reset_q  <= 1'b0;
      rst_seen_q    <= 1'b0;
      rxq_q         <= '{default: 8'h00};
      rxq_wr_q      <= '0;
      rxq_rd_q      <= '0;
      rxq_cnt_q     <= '0;
      rx_ovr_q      <= 1'b0;
      kcq_q         <= '{default: 8'h00};
      kc_wr_q       <= '0;
      kc_rd_q       <= '0;
      kc_cnt_q      <= '0;
      kc_data_q     <= 8'h00;
      kc_ovr_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      conv_code_q   <= conv_code_d;
      conv_strobe_q <= conv_strobe_d;
      conv_reset_q  <= conv_reset_d;
      rst_seen_q    <= rst_seen_d;
      rxq_q         <= rxq_d;
      rxq_wr_q      <= rxq_wr_d;
      rxq_rd_q      <= rxq_rd_d;
      rxq_cnt_q     <= rxq_cnt_d;
      rx_ovr_q      <= rx_ovr_d;
      kcq_q         <= kcq_d;
      kc_wr_q       <= kc_wr_d;
      kc_rd_q       <= kc_rd_d;
      kc_cnt_q      <= kc_cnt_d;
      kc_data_q     <= kc_data_d;
      kc_ovr_q      <= kc_ovr_d;
    end
  end

  assign bus.conv_strobe    = conv_strobe_q;
  assign bus.conv_code      = conv_code_q;
  assign bus.conv_reset     = conv_reset_q;
  assign bus.kbd_reset_seen = rst_seen_q;
  assign bus.kc_valid       = (kc_cnt_q != '0);
  assign bus.kc_data        = kc_data_q;
  assign bus.kc_count       = kc_cnt_q;
  assign bus.rx_overrun     = rx_ovr_q;
  assign bus.kc_overrun     = kc_ovr_q;
endmodule

// File: tb/tb_kbd_sequencer.sv
// Scoreboard bench for kbd_sequencer: stimulus queues expected bytes/keycodes, a negedge monitor compares.
module tb_kbd_sequencer;
  localparam int GAP   = 100;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  kbd_sequencer_if #(.DEPTH(DEPTH)) bus ();
  kbd_sequencer #(.GAP(GAP), .DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_conv [$];
  int         strobe_t [$];
  int         rst_t [$];
  logic [7:0] kc_mdl [$];
  bit         kc_ovr_mdl = 1'b0;
  int         last_strobe = -1;
  logic [7:0] last_read = 8'h00;
  logic [7:0] filt_list [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic bit is_filt(input logic [7:0] b);
    for (int i = 0; i < 7; i++) if (filt_list[i] == b) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor: compare against the scoreboard, then fold this cycle's inputs into the keycode model.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.conv_strobe) begin
        check("strobe_pending", exp_conv.size() > 0, 1);
        if (exp_conv.size() > 0) check("conv_code", bus.conv_code, exp_conv.pop_front());
        if (last_strobe >= 0) check("strobe_gap_min", (cyc - last_strobe) >= GAP + 2, 1);
        last_strobe = cyc;
        strobe_t.push_back(cyc);
      end
      if (bus.conv_reset || bus.kbd_reset_seen) begin
        check("reset_pulse_pair", bus.conv_reset, bus.kbd_reset_seen);
        rst_t.push_back(cyc);
      end
      check("kc_count", bus.kc_count, kc_mdl.size());
      check("kc_valid", bus.kc_valid, kc_mdl.size() != 0);
      check("kc_overrun", bus.kc_overrun, kc_ovr_mdl);
      if (kc_mdl.size() != 0) check("kc_data", bus.kc_data, kc_mdl[0]);
      if (bus.clr_overrun) kc_ovr_mdl = 1'b0;
      if (bus.kc_ack && kc_mdl.size() != 0) last_read = kc_mdl.pop_front();
      if (bus.conv_valid) begin
        if (kc_mdl.size() < DEPTH) kc_mdl.push_back(bus.conv_keycode);
        else kc_ovr_mdl = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    if (!is_filt(b)) exp_conv.push_back(b);
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic push_kc(input logic [7:0] k, input bit ack);
    bus.conv_valid   = 1'b1;
    bus.conv_keycode = k;
    bus.kc_ack       = ack;
    step();
    bus.conv_valid = 1'b0;
    bus.kc_ack     = 1'b0;
  endtask

  task automatic ack_n(input int n);
    bus.kc_ack = 1'b1;
    wait_cycles(n);
    bus.kc_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_overrun = 1'b1;
    step();
    bus.clr_overrun = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    exp_conv.delete();
    kc_mdl.delete();
    kc_ovr_mdl  = 1'b0;
    last_strobe = -1;
  endtask

  task automatic release_reset();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    step();
  endtask

  int t0, t1, k, exp_rst;
  logic [7:0] b;

  initial begin
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    bus.conv_valid = 1'b0; bus.conv_keycode = 8'h00;
    bus.kc_ack = 1'b0; bus.clr_overrun = 1'b0;
    #2;
    check("rst_conv_strobe", bus.conv_strobe, 0);
    check("rst_conv_code", bus.conv_code, 0);
    check("rst_conv_reset", bus.conv_reset, 0);
    check("rst_kbd_reset_seen", bus.kbd_reset_seen, 0);
    check("rst_kc_valid", bus.kc_valid, 0);
    check("rst_kc_data", bus.kc_data, 0);
    check("rst_kc_count", bus.kc_count, 0);
    check("rst_rx_overrun", bus.rx_overrun, 0);
    check("rst_kc_overrun", bus.kc_overrun, 0);
    release_reset();

    // Forwarded bytes: latency and exact spacing
    strobe_t.delete();
    t0 = cyc;
    send(8'h1C); send(8'hF0); send(8'h1C);
    wait_cycles(3 * (GAP + 2) + 10);
    check("t1_strobe_count", strobe_t.size(), 3);
    if (strobe_t.size() == 3) begin
      check("t1_latency", strobe_t[0] - t0, 2);
      check("t1_spacing_a", strobe_t[1] - strobe_t[0], GAP + 2);
      check("t1_spacing_b", strobe_t[2] - strobe_t[1], GAP + 2);
    end
    check("t1_drained", exp_conv.size(), 0);
    check("t1_rx_overrun", bus.rx_overrun, 0);

    // Filtered responses
    strobe_t.delete(); rst_t.delete();
    send(8'hFA);
    t1 = cyc;
    send(8'hAA);
    wait_cycles(10);
    check("t2_no_strobe", strobe_t.size(), 0);
    check("t2_reset_pulses", rst_t.size(), 1);
    if (rst_t.size() == 1) check("t2_reset_latency", rst_t[0] - t1, 2);

    // Input queue overrun
    for (int i = 0; i < 6; i++) begin
      b = 8'h11 + 8'(i);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      if (i < 5) exp_conv.push_back(b);
      step();
    end
    bus.rx_valid = 1'b0;
    check("t3_rx_overrun_set", bus.rx_overrun, 1);
    wait_cycles(5 * (GAP + 2) + 10);
    check("t3_drained", exp_conv.size(), 0);
    pulse_clr();
    check("t3_rx_overrun_clr", bus.rx_overrun, 0);

    // Keycode FIFO overrun
    for (int i = 1; i <= 9; i++) push_kc(8'(i), 1'b0);
    check("t4_count_full", bus.kc_count, DEPTH);
    check("t4_kc_overrun", bus.kc_overrun, 1);
    ack_n(8);
    check("t4_last_read", last_read, 8);
    check("t4_empty", bus.kc_valid, 0);
    pulse_clr();
    check("t4_overrun_clr", bus.kc_overrun, 0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) push_kc(8'h21 + 8'(i), 1'b0);
    push_kc(8'h29, 1'b1);
    check("t5_count", bus.kc_count, DEPTH);
    check("t5_no_overrun", bus.kc_overrun, 0);
    ack_n(8);
    check("t5_last_read", last_read, 8'h29);
    check("t5_empty", bus.kc_valid, 0);

    // Empty FIFO with push and ack together: ack ignored
    push_kc(8'h3C, 1'b1);
    check("t5b_count", bus.kc_count, 1);
    ack_n(1);

    // Reset during WAIT
    for (int i = 0; i < 9; i++) push_kc(8'h51 + 8'(i), 1'b0);
    ack_n(5);
    check("t6_pre_count", bus.kc_count, 3);
    check("t6_pre_overrun", bus.kc_overrun, 1);
    send(8'h1C);
    wait_cycles(50);
    do_reset();
    #1;
    check("t6_kc_valid", bus.kc_valid, 0);
    check("t6_kc_count", bus.kc_count, 0);
    check("t6_conv_strobe", bus.conv_strobe, 0);
    check("t6_kc_overrun", bus.kc_overrun, 0);
    check("t6_rx_overrun", bus.rx_overrun, 0);
    release_reset();
    strobe_t.delete();
    t0 = cyc;
    send(8'h2D);
    wait_cycles(GAP + 10);
    check("t6_strobe_count", strobe_t.size(), 1);
    if (strobe_t.size() == 1) check("t6_latency", strobe_t[0] - t0, 2);

    // Reset while the strobe is high
    send(8'h4B);
    step();
    check("t7_strobe_high", bus.conv_strobe, 1);
    check("t7_code", bus.conv_code, 8'h4B);
    do_reset();
    #1;
    check("t7_strobe_async_low", bus.conv_strobe, 0);
    release_reset();
    strobe_t.delete();
    wait_cycles(GAP + 10);
    check("t7_no_late_strobe", strobe_t.size(), 0);

    // Random scan-byte bursts
    rst_t.delete();
    exp_rst = 0;
    for (int n = 0; n < 8; n++) begin
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) begin
        b = ($urandom_range(0, 2) == 0) ? filt_list[$urandom_range(0, 6)] : 8'($urandom);
        if (b == 8'hAA) exp_rst++;
        send(b);
      end
      wait_cycles(k * (GAP + 2) + 10);
    end
    check("rnd_drained", exp_conv.size(), 0);
    check("rnd_reset_pulses", rst_t.size(), exp_rst);
    check("rnd_rx_overrun", bus.rx_overrun, 0);

    // Random keycode traffic
    for (int n = 0; n < 1200; n++) begin
      bus.conv_valid   = ($urandom_range(0, 2) == 0);
      bus.conv_keycode = 8'($urandom);
      bus.kc_ack       = (n < 600) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 1) == 0);
      bus.clr_overrun  = ($urandom_range(0, 40) == 0);
      step();
    end
    bus.conv_valid = 1'b0; bus.clr_overrun = 1'b0;
    ack_n(DEPTH + 1);
    check("rnd_kc_empty", bus.kc_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
